gpc_fetch_ctrl: RTL
===================

# gpc_fetch_ctrl

Instruction-fetch sequencer for the GPC single-cycle core. It owns the instruction-memory request/acknowledge handshake, latches the fetched word, and issues a one-cycle `core_step` enable so the core's PC and register file advance exactly once per fetched instruction. It also provides run, single-step, ebreak-halt and fetch-fault control. It sits between the core (pc/inst/ebreak) and the instruction bus.

## Interface
- `WIDTH`, 32, address/PC width.
- `PC_START`, 32'h80000000, reset value of `imem_addr`.
- `TIMEOUT`, 255, maximum wait cycles in FETCH before a fault; 8-bit counter, legal range 1..255.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-low (0 = reset).
- `run_en`  in  1  level; a rising edge starts free-run and the level sustains it.
- `step`  in  1  one-cycle pulse; executes one instruction when halted.
- `core_pc`  in  WIDTH  current PC from the core.
- `core_ebreak`  in  1  core's ebreak decode of `core_inst`; sampled only in EXEC.
- `core_step`  out  1  core clock-enable; the core updates PC/regs only when it is 1.
- `core_inst`  out  32  latched instruction word presented to the core.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  WIDTH  fetch address, registered.
- `imem_ack`  in  1  response valid.
- `imem_rdata`  in  32  response data.
- `imem_err`  in  1  bus error; qualified by `imem_ack`.
- `halted`  out  1  state is HALT.
- `ebreak_seen`  out  1  sticky flag: the last halt was caused by ebreak.
- `fault`  out  1  sticky: fetch error or timeout occurred.
- `fault_addr`  out  WIDTH  address of the faulting fetch.
- `icount`  out  32  number of retired instructions (EXEC cycles), wraps.

## Operation
- States: HALT, FETCH, EXEC, FAULT. Reset state is HALT.
- `run_q` registers `run_en` (reset 0). `run_rise` = `run_en & ~run_q`.
- `single` is a flag register set when leaving HALT via `step`.
- **HALT**
  - `run_rise` → FETCH, `single`=0, `ebreak_seen`=0.
  - else `step` → FETCH, `single`=1, `ebreak_seen`=0.
  - If both occur in the same cycle, `run_rise` wins.
  - On every transition into FETCH, `imem_addr` ← `core_pc` and the timeout counter ← 0.
- **FETCH**
  - `imem_req`=1 and `imem_addr` is held stable.
  - `imem_ack & ~imem_err` → `core_inst` ← `imem_rdata`, go to EXEC.
  - `imem_ack & imem_err` → FAULT, `fault_addr` ← `imem_addr`.
  - No ack and counter == `TIMEOUT` → FAULT, `fault_addr` ← `imem_addr`; otherwise the counter increments.
  - An ack arriving in the timeout cycle wins over the timeout.
- **EXEC**
  - `core_step`=1 for exactly this cycle; `icount` += 1 (0xFFFFFFFF → 0).
  - Next state, in priority order:
    - `core_ebreak` → HALT, `ebreak_seen`=1.
    - else `single` or `~run_en` → HALT.
    - else → FETCH with `imem_addr` ← next PC. The next PC is `core_pc` as updated by this step, so it is sampled in the first FETCH cycle: `imem_addr` is loaded on FETCH entry from `core_pc` one cycle later. Implementation: register a `load_addr` flag and load `imem_addr` in the first FETCH cycle; `imem_req` is 0 in that cycle.
- **FAULT**: terminal until reset. `core_step`=0, `imem_req`=0.
- Inputs ignored by state:
  - `imem_ack` outside FETCH.
  - `step` and `run_rise` outside HALT.
  - `run_en` falling during FETCH takes effect at the following EXEC.
- Reset values:
  - state HALT, `halted`=1.
  - `core_step`=0, `imem_req`=0, `imem_addr`=`PC_START`.
  - `core_inst`=32'h00000013 (nop).
  - `ebreak_seen`=0, `fault`=0, `fault_addr`=0, `icount`=0, counter=0, `single`=0.
- Reset mid-fetch abandons the request: `imem_req` is 0 the cycle after the reset edge. The memory must tolerate an abandoned request.

## Timing
- `halted`, `fault`, `imem_req` and `core_step` are decoded from the registered state; none is combinational from inputs.
- The first FETCH cycle after EXEC is the address-load cycle (`imem_req`=0). The request is asserted from the second FETCH cycle.
- From HALT, the request is asserted in the first FETCH cycle.
- Zero-wait memory (ack in the same cycle as req):
  - Steady run costs 3 cycles per instruction: load, req+ack, EXEC.
  - The first instruction after HALT costs 2 cycles.
- `core_inst` is valid from the EXEC cycle and holds until the next accepted ack.
- The timeout counter counts only req-asserted cycles, so a fault is raised after `TIMEOUT`+1 unacknowledged req cycles.

## Test plan
- Reset with `rst`=0 for 2 cycles → `halted`=1, `imem_addr`=0x80000000, `core_inst`=0x00000013, `icount`=0, `imem_req`=0.
- `run_en` 0→1 with a zero-wait memory returning nop, `core_pc` advancing by 4 per step → fetches at 0x80000000, 0x80000004, 0x80000008; `core_step` high once every 3 cycles after the first; `icount`=3 after 3 EXECs.
- `step` pulse while halted → exactly one `core_step` pulse, `icount`+1, back to HALT; a second `step` pulse issued during FETCH is ignored.
- Word 0x00100073 with `core_ebreak`=1 in EXEC → HALT, `ebreak_seen`=1, `icount` includes the ebreak; `run_en` held high does not restart; toggling `run_en` 0→1 resumes and clears `ebreak_seen`.
- Memory never acks, `TIMEOUT`=4 → `fault`=1 after 5 req cycles, `fault_addr`=request address, `imem_req`=0 afterward; ack with `imem_err`=1 also faults. Ack arriving in the 5th cycle → no fault.
- `rst`=0 asserted in the middle of a FETCH wait → next cycle `imem_req`=0, state HALT, counters cleared; `icount` at 0xFFFFFFFF wraps to 0 on the next EXEC.

Source files
------------

// File: rtl/gpc_fetch_ctrl_if.sv
// rtl/gpc_fetch_ctrl_if.sv - instruction-memory request/acknowledge bus for the GPC fetch sequencer
interface gpc_fetch_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [31:0]      imem_rdata;
    logic             imem_err;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        input  imem_err
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        output imem_err
    );
endinterface

// File: rtl/gpc_fetch_ctrl.sv
// rtl/gpc_fetch_ctrl.sv - fetch sequencer issuing one core_step per fetched instruction
module gpc_fetch_ctrl #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] PC_START = 32'h80000000,
    parameter int               TIMEOUT  = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run_en,
    input  logic                 step,
    input  logic [WIDTH-1:0]     core_pc,
    input  logic                 core_ebreak,
    output logic                 core_step,
    output logic [31:0]          core_inst,
    gpc_fetch_ctrl_if.master     imem,
    output logic                 halted,
    output logic                 ebreak_seen,
    output logic                 fault,
    output logic [WIDTH-1:0]     fault_addr,
    output logic [31:0]          icount
);
    localparam logic [7:0]  TMO = 8'(TIMEOUT);
    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {S_HALT, S_FETCH, S_EXEC, S_FAULT} state_t;

    state_t           r_state;
    logic             r_run_q;
    logic             r_single;
    logic             r_load_addr;
    logic [7:0]       r_cnt;
    logic [WIDTH-1:0] r_addr;
    logic [31:0]      r_inst;
    logic             r_ebreak_seen;
    logic             r_fault;
    logic [WIDTH-1:0] r_fault_addr;
    logic [31:0]      r_icount;
    logic             w_run_rise;

    assign w_run_rise = run_en & ~r_run_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_HALT;
            r_run_q       <= 1'b0;
            r_single      <= 1'b0;
            r_load_addr   <= 1'b0;
            r_cnt         <= 8'd0;
            r_addr        <= PC_START;
            r_inst        <= NOP;
            r_ebreak_seen <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_addr  <= '0;
            r_icount      <= 32'd0;
        end else begin
            r_run_q <= run_en;
            unique case (r_state)
                S_HALT: begin
                    if (w_run_rise || step) begin
                        r_state       <= S_FETCH;
                        r_single      <= ~w_run_rise;
                        r_ebreak_seen <= 1'b0;
                        r_addr        <= core_pc;
                        r_cnt         <= 8'd0;
                        r_load_addr   <= 1'b0;
                    end
                end
                S_FETCH: begin
                    // After EXEC the core PC only settles one cycle later, so grab it here before requesting.
                    if (r_load_addr) begin
                        r_addr      <= core_pc;
                        r_load_addr <= 1'b0;
                    end else if (imem.imem_ack) begin
                        if (imem.imem_err) begin
                            r_state      <= S_FAULT;
                            r_fault      <= 1'b1;
                            r_fault_addr <= r_addr;
                        end else begin
                            r_inst  <= imem.imem_rdata;
                            r_state <= S_EXEC;
                        end
                    end else if (r_cnt == TMO) begin
                        r_state      <= S_FAULT;
                        r_fault      <= 1'b1;
                        r_fault_addr <= r_addr;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_EXEC: begin
                    r_icount <= r_icount + 32'd1;
                    if (core_ebreak) begin
                        r_state       <= S_HALT;
                        r_ebreak_seen <= 1'b1;
                    end else if (r_single || !run_en) begin
                        r_state <= S_HALT;
                    end else begin
                        r_state     <= S_FETCH;
                        r_load_addr <= 1'b1;
                        r_cnt       <= 8'd0;
                    end
                end
                S_FAULT: r_state <= S_FAULT;
                default: r_state <= S_HALT;
            endcase
        end
    end

    assign imem.imem_req  = (r_state == S_FETCH) && !r_load_addr;
    assign imem.imem_addr = r_addr;
    assign core_step      = (r_state == S_EXEC);
    assign halted         = (r_state == S_HALT);
    assign core_inst      = r_inst;
    assign ebreak_seen    = r_ebreak_seen;
    assign fault          = r_fault;
    assign fault_addr     = r_fault_addr;
    assign icount         = r_icount;
endmodule
